// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline with a multi-cycle EX occupancy FSM.
// Optional saturating stall counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit_mc #(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 4,
   parameter int PERF_W  = 16
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic [REG_AW-1:0] RsE,
   input  logic [REG_AW-1:0] RtE,
   input  logic [REG_AW-1:0] WriteRegE,
   input  logic [REG_AW-1:0] WriteRegM,
   input  logic [REG_AW-1:0] WriteRegW,
   input  logic              RegWriteE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              MemtoRegE,
   input  logic              MemtoRegM,
   input  logic              BranchD,
   input  logic              PCSrcD,
   input  logic              MulStartE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              ForwardAD,
   output logic              ForwardBD,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic              MulBusy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] PerfLwStall,
   output logic [PERF_W-1:0] PerfBrStall,
   output logic [PERF_W-1:0] PerfMulStall
`endif
);

   localparam int CW = $clog2(MUL_LAT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lwstall, branchstall, hz;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      MulBusy = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MulStartE) begin
               MulBusy = 1'b1;
               if (MUL_LAT == 2) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  cnt_d   = CW'(MUL_LAT - 2);
               end
            end
         end
         S_RUN: begin
            MulBusy = 1'b1;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         // The op leaves EX this cycle; a new MulStartE belongs to the next op.
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (RsE != '0 && RsE == WriteRegM && RegWriteM)      ForwardAE = 2'b10;
      else if (RsE != '0 && RsE == WriteRegW && RegWriteW) ForwardAE = 2'b01;
      if (RtE != '0 && RtE == WriteRegM && RegWriteM)      ForwardBE = 2'b10;
      else if (RtE != '0 && RtE == WriteRegW && RegWriteW) ForwardBE = 2'b01;
   end

   assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
   assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

   assign lwstall     = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
   assign branchstall = BranchD &&
                        ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                         (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
   assign hz          = lwstall || branchstall;

   always_comb begin
      StallF = hz;
      StallD = hz;
      StallE = 1'b0;
      FlushE = hz;
      FlushM = 1'b0;
      FlushD = PCSrcD && !hz;
      // A held EX stage drains bubbles into MEM and masks every other request.
      if (MulBusy) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         FlushE = 1'b0;
         FlushM = 1'b1;
         FlushD = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [2:0]        perf_inc;
   logic [PERF_W-1:0] perf_q [3];

   assign perf_inc = {MulBusy, branchstall && !MulBusy, lwstall && !MulBusy};

   for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      always_ff @(posedge CLK) begin
         if (reset)                                perf_q[gi] <= '0;
         else if (perf_inc[gi] && perf_q[gi] != '1) perf_q[gi] <= perf_q[gi] + 1'b1;
      end
   end

   assign PerfLwStall  = perf_q[0];
   assign PerfBrStall  = perf_q[1];
   assign PerfMulStall = perf_q[2];
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: a MUL_LAT=4 instance and a MUL_LAT=2/PERF_W=2 instance share stimulus.
module tb_hazard_unit_mc;

   logic       CLK = 1'b0;
   logic       reset;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
   logic       BranchD, PCSrcD, MulStartE;

   logic [1:0] ForwardAE, ForwardBE, ForwardAE2, ForwardBE2;
   logic       ForwardAD, ForwardBD, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy;
   logic       ForwardAD2, ForwardBD2, StallF2, StallD2, StallE2, FlushD2, FlushE2, FlushM2, MulBusy2;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] PerfLw, PerfBr, PerfMul;
   logic [1:0]  PerfLw2, PerfBr2, PerfMul2;
`endif

   int total = 0;
   int bad   = 0;

   // obs bit order: FAE[12:11] FBE[10:9] FAD FBD SF SD SE FD FE FM MB
   logic [12:0] obs;
   assign obs = {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, StallE,
                 FlushD, FlushE, FlushM, MulBusy};

   localparam logic [12:0] BUSY = 13'b00_00_0_0_1_1_1_0_0_1_1;
   localparam logic [12:0] HZ   = 13'b00_00_0_0_1_1_0_0_1_0_0;

   typedef struct {
      logic [12:0] obs;
      logic        mb2;
   } exp_t;

   exp_t sb[$];
   exp_t got;
   exp_t e;

   hazard_unit_mc #(.REG_AW(5), .MUL_LAT(4), .PERF_W(16)) dut (
      .CLK(CLK), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
      .MulStartE(MulStartE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .StallF(StallF), .StallD(StallD),
      .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MulBusy(MulBusy)
`ifdef HAZARD_PERF_CNT_EN
      , .PerfLwStall(PerfLw), .PerfBrStall(PerfBr), .PerfMulStall(PerfMul)
`endif
   );

   hazard_unit_mc #(.REG_AW(5), .MUL_LAT(2), .PERF_W(2)) dut2 (
      .CLK(CLK), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
      .MulStartE(MulStartE), .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2),
      .ForwardAD(ForwardAD2), .ForwardBD(ForwardBD2), .StallF(StallF2), .StallD(StallD2),
      .StallE(StallE2), .FlushD(FlushD2), .FlushE(FlushE2), .FlushM(FlushM2), .MulBusy(MulBusy2)
`ifdef HAZARD_PERF_CNT_EN
      , .PerfLwStall(PerfLw2), .PerfBrStall(PerfBr2), .PerfMulStall(PerfMul2)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: total=%0d bad=%0d not finished in time", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic clear_in();
      reset = 1'b0;
      {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
      {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
      {BranchD, PCSrcD, MulStartE} = '0;
   endtask

   // Inputs are applied at the negedge; outputs settle and are sampled 2ns later.
   task automatic apply(input exp_t ex);
      sb.push_back(ex);
      #2;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      clear_in();
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      e.obs = '0; e.mb2 = 1'b0;
      apply(e);
      got = sb.pop_front();
      total++;
      if (obs !== got.obs || MulBusy2 !== got.mb2) begin
         bad++;
         $display("FAIL reset: obs=%b mb2=%b want obs=%b mb2=%b", obs, MulBusy2, got.obs, got.mb2);
      end else $display("reset: obs=%b ok", obs);
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if ({PerfLw, PerfBr, PerfMul} !== 48'd0) begin
         bad++;
         $display("FAIL reset_perf: %0d %0d %0d want 0 0 0", PerfLw, PerfBr, PerfMul);
      end
`endif
   endtask

   task automatic test_forward();
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         clear_in();
         case (k)
            0: begin RsE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
                     e.obs = 13'b10_00_0_0_0000000; end
            1: begin RsE = 0; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
                     e.obs = 13'b00_00_0_0_0000000; end
            2: begin RsE = 5; RtE = 6; WriteRegM = 6; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
                     e.obs = 13'b01_10_0_0_0000000; end
            3: begin RsE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 0; RegWriteW = 1;
                     e.obs = 13'b01_00_0_0_0000000; end
            default: begin RsD = 7; RtD = 8; WriteRegM = 8; RegWriteM = 1;
                     e.obs = 13'b00_00_0_1_0000000; end
         endcase
         e.mb2 = 1'b0;
         apply(e);
         got = sb.pop_front();
         total++;
         if (obs !== got.obs) begin
            bad++;
            $display("FAIL forward[%0d]: obs=%b want %b", k, obs, got.obs);
         end else $display("forward[%0d]: obs=%b ok", k, obs);
      end
   endtask

   task automatic test_load_use();
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         clear_in();
         RtE = 3; RsD = 3;
         MemtoRegE = (k == 0);
         e.obs = (k == 0) ? HZ : 13'b0;
         e.mb2 = 1'b0;
         apply(e);
         got = sb.pop_front();
         total++;
         if (obs !== got.obs) begin
            bad++;
            $display("FAIL load_use[%0d]: obs=%b want %b", k, obs, got.obs);
         end else $display("load_use[%0d]: obs=%b ok", k, obs);
      end
   endtask

   task automatic test_branch();
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         clear_in();
         BranchD = 1; PCSrcD = 1; RsD = 4;
         if (k == 0) begin RegWriteE = 1; WriteRegE = 4; end
         e.obs = (k == 0) ? HZ : 13'b00_00_0_0_0_0_0_1_0_0_0;
         e.mb2 = 1'b0;
         apply(e);
         got = sb.pop_front();
         total++;
         if (obs !== got.obs) begin
            bad++;
            $display("FAIL branch[%0d]: obs=%b want %b", k, obs, got.obs);
         end else $display("branch[%0d]: obs=%b ok", k, obs);
      end
   endtask

   // Cycles 0-3: first op (lwstall in c1, PCSrcD in c2, new start ignored in DONE c3);
   // cycles 4-7: back-to-back second op. dut2 (MUL_LAT=2) sees the same MulStartE.
   task automatic test_mul_back_to_back();
      logic [12:0] eo [8];
      logic        em [8];
      eo = '{BUSY, BUSY, BUSY, 13'b0, BUSY, BUSY, BUSY, 13'b0};
      em = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         clear_in();
         MulStartE = (k == 0) || (k == 3) || (k == 4);
         if (k == 1) begin MemtoRegE = 1; RtE = 3; RsD = 3; end
         if (k == 2) PCSrcD = 1;
         e.obs = eo[k]; e.mb2 = em[k];
         apply(e);
         got = sb.pop_front();
         total++;
         if (obs !== got.obs || MulBusy2 !== got.mb2) begin
            bad++;
            $display("FAIL mul[%0d]: obs=%b mb2=%b want obs=%b mb2=%b",
                     k, obs, MulBusy2, got.obs, got.mb2);
         end else $display("mul[%0d]: obs=%b mb2=%b ok", k, obs, MulBusy2);
      end
   endtask

   task automatic test_reset_mid_run();
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         clear_in();
         MulStartE = (k == 0);
         reset     = (k == 1);
         e.obs = (k < 2) ? BUSY : 13'b0;
         e.mb2 = (k == 0);
         apply(e);
         got = sb.pop_front();
         total++;
         if (obs !== got.obs || MulBusy2 !== got.mb2) begin
            bad++;
            $display("FAIL reset_mid_run[%0d]: obs=%b mb2=%b want obs=%b mb2=%b",
                     k, obs, MulBusy2, got.obs, got.mb2);
         end else $display("reset_mid_run[%0d]: obs=%b ok", k, obs);
      end
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if (PerfMul !== 16'd0) begin
         bad++;
         $display("FAIL perf_after_reset: PerfMul=%0d want 0", PerfMul);
      end
`endif
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf();
      logic [15:0] want_mul;
      @(negedge CLK);
      clear_in();
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         clear_in();
         MulStartE = (k == 0);
         want_mul = (k < 4) ? 16'(k) : 16'd3;
         #2;
         total++;
         if (PerfMul !== want_mul) begin
            bad++;
            $display("FAIL perf_mul[%0d]: PerfMul=%0d want %0d", k, PerfMul, want_mul);
         end else $display("perf_mul[%0d]: PerfMul=%0d ok", k, PerfMul);
      end
      // dut2 is busy every other cycle under a constant start; 5 busy cycles saturate at 3.
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         clear_in();
         MulStartE = 1'b1;
      end
      @(negedge CLK);
      clear_in();
      #2;
      total++;
      if (PerfMul2 !== 2'd3) begin
         bad++;
         $display("FAIL perf_sat: PerfMul2=%0d want 3", PerfMul2);
      end else $display("perf_sat: PerfMul2=%0d ok", PerfMul2);
   endtask
`endif

   initial begin
      clear_in();
      reset = 1'b1;
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_mul_back_to_back();
      test_reset_mid_run();
`ifdef HAZARD_PERF_CNT_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It generates EX/ID forwarding selects, load-use and branch stalls, and branch flushes. It adds a multi-cycle EX-unit occupancy state machine, so a multiply can hold EX for `MUL_LAT` cycles while younger stages stall and bubbles drain into MEM. It sits beside the four pipeline registers and drives their enable and clear inputs.

## Interface
Parameters:
- `REG_AW`, default 5: register-index width.
- `MUL_LAT`, default 4: cycles a multi-cycle op occupies EX. Legal range 2..255.
- `PERF_W`, default 16: performance counter width (only with the macro).

Ports:
- `CLK` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `RsD`, `RtD`, `RsE`, `RtE` in `REG_AW`: source registers in ID and EX.
- `WriteRegE`, `WriteRegM`, `WriteRegW` in `REG_AW`: destination registers in EX, MEM and WB.
- `RegWriteE`, `RegWriteM`, `RegWriteW` in 1: register-write enables.
- `MemtoRegE`, `MemtoRegM` in 1: the instruction is a load.
- `BranchD` in 1: a branch is in ID.
- `PCSrcD` in 1: the branch is taken.
- `MulStartE` in 1: the instruction in EX is multi-cycle.
- `ForwardAE`, `ForwardBE` out 2: EX operand select. 00 = register file, 01 = `ResultW`, 10 = `ALUOutM`.
- `ForwardAD`, `ForwardBD` out 1: ID comparator takes `ALUOutM`.
- `StallF`, `StallD`, `StallE` out 1: hold the PC, IF/ID and ID/EX registers.
- `FlushD`, `FlushE`, `FlushM` out 1: clear IF/ID, ID/EX and EX/MEM.
- `MulBusy` out 1: the multi-cycle op is holding EX this cycle.

## Operation
Forwarding (combinational):
- `ForwardAE` is 10 when RsE≠0, RsE=WriteRegM and RegWriteM.
- Otherwise `ForwardAE` is 01 when RsE≠0, RsE=WriteRegW and RegWriteW.
- Otherwise `ForwardAE` is 00. MEM has priority over WB.
- `ForwardBE` follows the same rules using RtE.
- `ForwardAD` = RsD≠0 & RsD=WriteRegM & RegWriteM. `ForwardBD` is the same with RtD.

Hazard terms:
- lwstall = MemtoRegE & (RtE=RsD | RtE=RtD).
- branchstall = BranchD & [(RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})].
- hz = lwstall | branchstall.

Multi-cycle state machine. States are IDLE, RUN and DONE, with a counter `cnt` of width clog2(`MUL_LAT`).
- IDLE & MulStartE: `MulBusy`=1. The next state is DONE if `MUL_LAT`=2. Otherwise it is RUN with `cnt`=`MUL_LAT`-2.
- RUN: `MulBusy`=1 and `cnt` decrements. When `cnt`=1, the next state is DONE.
- DONE: `MulBusy`=0 and MulStartE is ignored. The next state is always IDLE.
- The multi-cycle unit latches its operands in the start cycle. Forwarding selects in later busy cycles are don't-care for it.

Outputs, in priority order:
- When `MulBusy`: `StallF`=`StallD`=`StallE`=1, `FlushM`=1, `FlushE`=0, `FlushD`=0. hz and PCSrcD are masked.
- Otherwise: `StallF`=`StallD`=hz, `StallE`=0, `FlushE`=hz and `FlushM`=0.
- `FlushD`=PCSrcD & ~`StallD`. Stall beats clear.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the current state. They take effect at the next `CLK` edge.
- The FSM state and `cnt` register on `CLK`.
- Occupancy: a multi-cycle op entering EX in cycle 0 gets `MulBusy` in cycles 0..`MUL_LAT`-2. It leaves EX at the end of cycle `MUL_LAT`-1, which is the DONE cycle.
- Back-to-back multi-cycle ops: the second op enters EX after DONE and is seen in IDLE, so it starts a fresh sequence with no gap cycle lost.
- Reset: on the edge with `reset`=1, the state becomes IDLE, `cnt` becomes 0 and the performance counters become 0. This applies mid-RUN as well; the sequence is abandoned.
- With all inputs 0 after reset, every output is 0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds output ports `PerfLwStall`, `PerfBrStall` and `PerfMulStall`, each `PERF_W` wide.
  - Each counter increments on every clock in which lwstall & ~`MulBusy`, branchstall & ~`MulBusy`, or `MulBusy` respectively is true.
  - Each counter saturates at all-ones and is cleared by `reset`.
- `HAZARD_PERF_CNT_EN` undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Test plan
- Forward priority: RsE=5, WriteRegM=5, WriteRegW=5, RegWriteM=RegWriteW=1 → `ForwardAE`=10. With RsE=0 and the same other inputs → `ForwardAE`=00.
- Load-use: MemtoRegE=1, RtE=3, RsD=3 → `StallF`=`StallD`=`FlushE`=1 and `StallE`=0 for exactly one cycle.
- Taken branch with stall: BranchD=1, RegWriteE=1, WriteRegE=RsD=4, PCSrcD=1 → `FlushD`=0 and `StallD`=1. The next cycle, with the hazard gone → `FlushD`=1.
- Multi-cycle op, `MUL_LAT`=4: pulse MulStartE high in EX → `MulBusy`/`StallE`/`FlushM`=1 in cycles 0-2 and 0 in cycle 3. A concurrent lwstall in cycle 1 gives `FlushE`=0. Repeat with `MUL_LAT`=2 → busy for 1 cycle only.
- Reset mid-RUN at cycle 1 → `MulBusy`=0 in cycle 2. With `HAZARD_PERF_CNT_EN`, `PerfMulStall` counts 0,1,2,3 over three busy cycles; after reset it reads 0. With `PERF_W`=2, it holds at 3 once saturated.
